// File: rtl/spi_slave.sv
// SPI slave: oversamples sck/cs_n/mosi on clk and exchanges N-bit words with the master.
// Local side has a one-entry valid/ready transmit buffer and a one-clk receive strobe.
module spi_slave #(
    parameter int unsigned N  = 8,
    parameter int unsigned CW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sck,
    input  logic         cs_n,
    input  logic         mosi,
    output logic         miso,
    input  logic [N-1:0] tx_data,
    input  logic         tx_valid,
    output logic         tx_ready,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         underrun,
    output logic         frame_err,
    output logic         busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  shreg;
    logic [N-1:0]  tx_buf;

    logic sck_s1, sck_s2, sck_d;
    logic cs_s1, cs_s2, cs_d;
    logic mosi_s1, mosi_s2;

    logic          sck_fall_c;
    logic          cs_fall_c;
    logic          cs_rise_c;
    logic          last_bit_c;
    logic          load_c;
    logic          accept_c;
    logic          full_c;
    logic [N-1:0]  load_val_c;
    logic [N-1:0]  shifted_c;

    // Two-flop synchronisers plus a delay flop on sck and cs_n for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_s1  <= 1'b0;
            sck_s2  <= 1'b0;
            sck_d   <= 1'b0;
            cs_s1   <= 1'b1;
            cs_s2   <= 1'b1;
            cs_d    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    always_comb begin
        sck_fall_c = ~sck_s2 & sck_d;
        cs_fall_c  = ~cs_s2 & cs_d;
        cs_rise_c  = cs_s2 & ~cs_d;
        last_bit_c = (bit_cnt == CW'(N - 1));
        full_c     = ~tx_ready;
        shifted_c  = {shreg[N-2:0], mosi_s2};
        load_val_c = full_c ? tx_buf : '0;
        // A word slot starts at frame start or when a word completes without an abort
        load_c     = ((state == IDLE) & cs_fall_c)
                   | ((state == SHIFT) & ~cs_rise_c & sck_fall_c & last_bit_c);
        // A word arriving in the cycle the buffer drains refills it straight away
        accept_c   = tx_valid & (~full_c | load_c);
    end

    // Transmit buffer; tx_ready is the inverted full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ready <= 1'b1;
            tx_buf   <= '0;
        end else begin
            if (accept_c) begin
                tx_buf   <= tx_data;
                tx_ready <= 1'b0;
            end else if (load_c) begin
                tx_ready <= 1'b1;
            end
        end
    end

    // Frame FSM with registered serial output and strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            miso      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    miso    <= 1'b0;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                    if (cs_fall_c) begin
                        state    <= SHIFT;
                        busy     <= 1'b1;
                        shreg    <= load_val_c;
                        miso     <= load_val_c[N-1];
                        underrun <= full_c ? 1'b0 : 1'b1;
                    end
                end
                SHIFT: begin
                    busy <= 1'b1;
                    if (cs_rise_c) begin
                        // Abort: a partial word is dropped and flagged
                        state     <= IDLE;
                        busy      <= 1'b0;
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                        frame_err <= (bit_cnt != '0);
                    end else if (sck_fall_c) begin
                        if (last_bit_c) begin
                            rx_data  <= shifted_c;
                            rx_valid <= 1'b1;
                            shreg    <= load_val_c;
                            miso     <= load_val_c[N-1];
                            underrun <= full_c ? 1'b0 : 1'b1;
                            bit_cnt  <= '0;
                        end else begin
                            shreg   <= shifted_c;
                            miso    <= shreg[N-2];
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    miso  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural SPI master, table of single-word frames,
// hand-written multi-cycle sequences and an rx scoreboard queue.
module tb_spi_slave;

    logic       clk;
    logic       rst;
    logic       sck;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       underrun;
    logic       frame_err;
    logic       busy;

    spi_slave #(.N(8), .CW(3)) dut (
        .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun),
        .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rxv    = 0;
    int n_und    = 0;
    int n_fe     = 0;
    logic [7:0] rx_q[$];
    logic [7:0] last_rx;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%02h required=%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: pop expected receive words as rx_valid strobes arrive
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                n_rxv++;
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected actual=%02h required=none", rx_data);
                end else begin
                    chk("rx_data", rx_data, rx_q.pop_front());
                end
            end
            if (underrun)  n_und++;
            if (frame_err) n_fe++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic push_tx(input logic [7:0] w);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (tx_ready) break;
        end
        chk("push_ready", 8'(tx_ready), 8'd1);
        tx_valid = 1'b1;
        tx_data  = w;
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    // Master: change mosi and sample miso on rising sck, sck high/low ~8 clk each
    task automatic send_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(posedge clk); #1;
            sck   = 1'b1;
            mi[i] = miso;
            mosi  = mo[i];
            repeat (7) @(posedge clk);
            #1 sck = 1'b0;
            repeat (7) @(posedge clk);
        end
    endtask

    task automatic frame_begin();
        @(posedge clk); #1;
        cs_n = 1'b0;
        repeat (6) @(posedge clk);
    endtask

    task automatic frame_end();
        repeat (6) @(posedge clk);
        #1 cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] mo;
        logic       preload;
    } vec_t;

    vec_t       vecs[4];
    logic [7:0] got, got2;

    initial begin
        vecs[0] = '{tx: 8'hA5, mo: 8'h3C, preload: 1'b1};
        vecs[1] = '{tx: 8'h00, mo: 8'hFF, preload: 1'b0};
        vecs[2] = '{tx: 8'h0F, mo: 8'hF0, preload: 1'b1};
        vecs[3] = '{tx: 8'h80, mo: 8'h01, preload: 1'b1};

        rst = 1'b1; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0; last_rx = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_miso", 8'(miso), 8'd0);
        chk("rst_tx_ready", 8'(tx_ready), 8'd1);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_strobes", {5'd0, rx_valid, underrun, frame_err}, 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);

        // Single-word frames; a filler word is queued after the first load
        // so the load at word completion does not underrun.
        for (int v = 0; v < 4; v++) begin
            n_rxv = 0; n_und = 0;
            if (vecs[v].preload) push_tx(vecs[v].tx);
            rx_q.push_back(vecs[v].mo);
            frame_begin();
            push_tx(8'hEE);
            send_bits(vecs[v].mo, 8, got);
            frame_end();
            chk("tbl_miso_word", got, vecs[v].preload ? vecs[v].tx : 8'h00);
            chk("tbl_rx_count", 8'(n_rxv), 8'd1);
            chk("tbl_underrun", 8'(n_und), vecs[v].preload ? 8'd0 : 8'd1);
            chk("tbl_tx_ready", 8'(tx_ready), 8'd1);
            chk("tbl_busy", 8'(busy), 8'd0);
            last_rx = vecs[v].mo;
        end

        // Back-to-back words inside one cs_n window
        n_rxv = 0; n_und = 0;
        push_tx(8'h81);
        rx_q.push_back(8'h12);
        rx_q.push_back(8'h34);
        frame_begin();
        push_tx(8'h7E);
        send_bits(8'h12, 8, got);
        push_tx(8'h55);
        send_bits(8'h34, 8, got2);
        frame_end();
        chk("b2b_miso0", got, 8'h81);
        chk("b2b_miso1", got2, 8'h7E);
        chk("b2b_rx_count", 8'(n_rxv), 8'd2);
        chk("b2b_underrun", 8'(n_und), 8'd0);
        chk("b2b_rx_last", rx_data, 8'h34);
        last_rx = 8'h34;

        // Abort after 5 sck falls
        n_rxv = 0; n_fe = 0;
        push_tx(8'h5A);
        frame_begin();
        send_bits(8'hAA, 5, got);
        frame_end();
        chk("abort_frame_err", 8'(n_fe), 8'd1);
        chk("abort_rx_count", 8'(n_rxv), 8'd0);
        chk("abort_rx_hold", rx_data, last_rx);
        chk("abort_busy", 8'(busy), 8'd0);
        chk("abort_miso", 8'(miso), 8'd0);
        chk("abort_miso_bits", got, 8'h58);

        // Reset mid-frame after 3 bits
        n_rxv = 0; n_fe = 0;
        push_tx(8'h99);
        frame_begin();
        send_bits(8'hF0, 3, got);
        @(posedge clk); #1;
        rst = 1'b1; cs_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        @(negedge clk);
        chk("mrst_busy", 8'(busy), 8'd0);
        chk("mrst_miso", 8'(miso), 8'd0);
        chk("mrst_tx_ready", 8'(tx_ready), 8'd1);
        chk("mrst_rx_data", rx_data, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("mrst_after_busy", 8'(busy), 8'd0);
        chk("mrst_after_ready", 8'(tx_ready), 8'd1);
        chk("mrst_no_strobes", 8'(n_rxv + n_fe), 8'd0);
        rx_q.push_back(8'hC3);
        frame_begin();
        push_tx(8'hEE);
        send_bits(8'hC3, 8, got);
        frame_end();
        chk("mrst_rx_count", 8'(n_rxv), 8'd1);
        chk("mrst_rx_data_c3", rx_data, 8'hC3);
        last_rx = 8'hC3;

        // Handshake collision: new word offered while the buffer drains into shreg
        n_rxv = 0;
        push_tx(8'hE7);
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 8'h3B;
        cs_n     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) break;
        end
        chk("coll_busy", 8'(busy), 8'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("coll_tx_ready", 8'(tx_ready), 8'd0);
        repeat (4) @(posedge clk);
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h02);
        send_bits(8'h01, 8, got);
        send_bits(8'h02, 8, got2);
        frame_end();
        chk("coll_miso0", got, 8'hE7);
        chk("coll_miso1", got2, 8'h3B);
        chk("coll_rx_count", 8'(n_rxv), 8'd2);
        chk("sb_drained", 8'(rx_q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
